// File: rtl/prog_sequencer.sv
// Program sequencer: fetches 9-bit instructions from a combinational instruction
// memory, follows taken branches via a branch table, and serves ACC constants.
module prog_sequencer #(
    parameter int         PC_W      = 10,
    parameter logic [8:0] HALT_INST = 9'h1FF,
    parameter logic [8:0] NOP_INST  = 9'h1E0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      inst,
    input  logic            branch_en,
    input  logic            fetch_acc_en,
    output logic [7:0]      acc_value,
    input  logic            lut_we,
    input  logic            lut_sel,
    input  logic [4:0]      lut_addr,
    input  logic [PC_W-1:0] lut_wdata,
    output logic            busy,
    output logic            done,
    output logic [15:0]     cycles
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [15:0]     cycles_nxt;
    logic [PC_W-1:0] branch_tbl [32];
    logic [7:0]      acc_tbl    [32];

    // fetch_acc_en only qualifies when the consumer samples acc_value
    logic unused_fetch_acc;
    assign unused_fetch_acc = fetch_acc_en;

    assign imem_addr = pc;
    assign inst      = (state == RUN) ? imem_data : NOP_INST;
    assign acc_value = acc_tbl[inst[4:0]];
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= '0;
            cycles <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            cycles <= cycles_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        cycles_nxt = cycles;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = RUN;
                    pc_nxt     = '0;
                    cycles_nxt = '0;
                end
            end
            RUN: begin
                if (cycles != 16'hFFFF)
                    cycles_nxt = cycles + 16'd1;
                if (inst == HALT_INST)
                    state_nxt = DONE;
                else if (branch_en)
                    pc_nxt = branch_tbl[inst[4:0]];
                else
                    pc_nxt = pc + PC_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Table reads are combinational off the registers, so a same-cycle write
    // is only seen from the following cycle on.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                branch_tbl[i] <= '0;
                acc_tbl[i]    <= '0;
            end
        end else if (lut_we) begin
            if (lut_sel)
                acc_tbl[lut_addr] <= lut_wdata[7:0];
            else
                branch_tbl[lut_addr] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: scoreboard of expected fetch addresses
// and ACC values, plus reset, wrap, table-collision and saturation scenarios.
module tb_prog_sequencer;

    localparam int         PC_W = 10;
    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] NOP  = 9'h1E0;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data, inst;
    logic            branch_en, fetch_acc_en;
    logic [7:0]      acc_value;
    logic            lut_we, lut_sel;
    logic [4:0]      lut_addr;
    logic [PC_W-1:0] lut_wdata;
    logic            busy, done;
    logic [15:0]     cycles;

    logic [8:0] imem [1024];

    typedef struct {
        logic [PC_W-1:0] addr;
        logic [7:0]      acc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;

    int              hook_step = -1;
    int              hook_kind = 0;
    logic [PC_W-1:0] hook_a;
    logic [PC_W-1:0] hook_d;
    logic            hook_sel;

    always #5 clk = ~clk;

    // Instruction memory and a toy decoder: 1011_xxxxx branches, 1100_xxxxx fetches ACC
    assign imem_data    = imem[imem_addr];
    assign branch_en    = (inst[8:5] == 4'hB);
    assign fetch_acc_en = (inst[8:5] == 4'hC);

    prog_sequencer #(.PC_W(PC_W), .HALT_INST(HALT), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data), .inst(inst),
        .branch_en(branch_en), .fetch_acc_en(fetch_acc_en), .acc_value(acc_value),
        .lut_we(lut_we), .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .busy(busy), .done(done), .cycles(cycles)
    );

    task automatic fill_imem(input logic [8:0] v);
        for (int i = 0; i < 1024; i++) imem[i] = v;
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; lut_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fill_imem(HALT);
        sb.delete();
    endtask

    task automatic write_lut(input logic sel, input logic [4:0] a, input logic [PC_W-1:0] d);
        lut_we = 1'b1; lut_sel = sel; lut_addr = a; lut_wdata = d;
        @(negedge clk);
        lut_we = 1'b0;
    endtask

    task automatic push(input logic [PC_W-1:0] a, input logic [7:0] acc);
        exp_t e;
        e.addr = a; e.acc = acc;
        sb.push_back(e);
    endtask

    // Launch a program, compare every RUN cycle against the scoreboard, then check DONE
    task automatic run_prog(input string name, input logic [PC_W-1:0] fin_addr,
                            input logic [15:0] fin_cycles, input int budget);
        exp_t e;
        int   steps = 0;
        start = 1'b1;
        @(negedge clk);
        while (!done && steps < budget) begin
            start = 1'b0; lut_we = 1'b0;
            if (busy) begin
                checks++;
                if (sb.size() == 0)
                    $display("FAIL %s extra_fetch addr=%0d expected no more RUN cycles", name, imem_addr);
                else begin
                    e = sb.pop_front();
                    if (imem_addr !== e.addr || acc_value !== e.acc)
                        $display("FAIL %s step%0d addr=%h acc=%h expected addr=%h acc=%h",
                                 name, steps, imem_addr, acc_value, e.addr, e.acc);
                    else passes++;
                end
            end
            if (steps == hook_step) begin
                case (hook_kind)
                    1: imem[hook_a] = hook_d[8:0];
                    2: begin lut_we = 1'b1; lut_sel = hook_sel; lut_addr = hook_a[4:0]; lut_wdata = hook_d; end
                    3: start = 1'b1;
                    default: ;
                endcase
            end
            steps++;
            @(negedge clk);
        end
        start = 1'b0; lut_we = 1'b0; hook_step = -1;
        checks++;
        if (!done || sb.size() != 0)
            $display("FAIL %s completion done=%b left=%0d expected done=1 left=0", name, done, sb.size());
        else passes++;
        checks++;
        if (cycles !== fin_cycles || imem_addr !== fin_addr || inst !== NOP || busy !== 1'b0)
            $display("FAIL %s done_state cycles=%0d addr=%h inst=%h busy=%b expected %0d %h %h 0",
                     name, cycles, imem_addr, inst, busy, fin_cycles, fin_addr, NOP);
        else passes++;
        sb.delete();
    endtask

    task automatic test_reset();
        fill_imem(9'h0AB);
        reset = 1'b1; start = 1'b1;
        lut_we = 1'b1; lut_sel = 1'b1; lut_addr = 5'd0; lut_wdata = 10'h077;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; lut_we = 1'b0;
        checks++;
        if (imem_addr !== 0 || inst !== NOP || acc_value !== 8'h00 ||
            busy !== 1'b0 || done !== 1'b0 || cycles !== 16'd0)
            $display("FAIL reset addr=%h inst=%h acc=%h busy=%b done=%b cyc=%0d expected 0 %h 00 0 0 0",
                     imem_addr, inst, acc_value, busy, done, cycles, NOP);
        else passes++;
    endtask

    task automatic test_straight_line();
        apply_reset();
        imem[0] = 9'h000; imem[1] = 9'h010; imem[2] = 9'h0C1; imem[3] = HALT;
        push(0, 0); push(1, 0); push(2, 0); push(3, 0);
        run_prog("straight", 10'd3, 16'd4, 20);
    endtask

    task automatic test_back_to_back();
        // restart from DONE; a start pulse mid-run must be ignored
        push(0, 0); push(1, 0); push(2, 0); push(3, 0);
        hook_step = 1; hook_kind = 3;
        run_prog("back_to_back", 10'd3, 16'd4, 20);
    endtask

    task automatic test_branch();
        apply_reset();
        write_lut(1'b0, 5'd5, 10'd20);
        imem[0] = 9'h000; imem[1] = 9'h000; imem[2] = 9'h165; imem[20] = 9'h000; imem[21] = HALT;
        push(0, 0); push(1, 0); push(2, 0); push(20, 0); push(21, 0);
        run_prog("branch", 10'd21, 16'd5, 20);
    endtask

    task automatic test_acc_fetch();
        apply_reset();
        write_lut(1'b1, 5'd7, 10'h2A5);
        write_lut(1'b1, 5'd31, 10'h03C);
        imem[0] = 9'h187; imem[1] = HALT;
        push(0, 8'hA5); push(1, 8'h3C);
        run_prog("acc_fetch", 10'd1, 16'd2, 10);
    endtask

    task automatic test_wrap();
        apply_reset();
        write_lut(1'b0, 5'd2, 10'h3FF);
        imem[0] = 9'h000; imem[1] = 9'h162; imem[10'h3FF] = 9'h000;
        // second visit to address 0 halts
        hook_step = 2; hook_kind = 1; hook_a = 10'd0; hook_d = {1'b0, HALT};
        push(0, 0); push(1, 0); push(10'h3FF, 0); push(0, 0);
        run_prog("wrap", 10'd0, 16'd4, 20);
    endtask

    task automatic test_collision();
        apply_reset();
        write_lut(1'b0, 5'd3, 10'd10);
        imem[0] = 9'h000; imem[1] = 9'h163; imem[10] = 9'h000; imem[11] = 9'h163; imem[50] = HALT;
        hook_step = 1; hook_kind = 2; hook_sel = 1'b0; hook_a = 10'd3; hook_d = 10'd50;
        push(0, 0); push(1, 0); push(10, 0); push(11, 0); push(50, 0);
        run_prog("collision", 10'd50, 16'd5, 20);
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        write_lut(1'b1, 5'd0, 10'h033);
        for (int i = 0; i < 10; i++) imem[i] = 9'h000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (cycles !== 16'd5 || busy !== 1'b1 || imem_addr !== 10'd5)
            $display("FAIL mid_run_pre cycles=%0d busy=%b addr=%0d expected 5 1 5", cycles, busy, imem_addr);
        else passes++;
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || imem_addr !== 0 || cycles !== 0 ||
            inst !== NOP || acc_value !== 8'h00)
            $display("FAIL mid_run_reset busy=%b done=%b addr=%h cyc=%0d inst=%h acc=%h expected 0 0 0 0 %h 00",
                     busy, done, imem_addr, cycles, inst, acc_value, NOP);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_run_idle busy=%b done=%b expected 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_saturation();
        apply_reset();
        fill_imem(9'h000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (65540) @(negedge clk);
        checks++;
        if (cycles !== 16'hFFFF || busy !== 1'b1)
            $display("FAIL saturation cycles=%h busy=%b expected ffff 1", cycles, busy);
        else passes++;
        apply_reset();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; lut_we = 1'b0; lut_sel = 1'b0;
        lut_addr = '0; lut_wdata = '0;
        hook_a = '0; hook_d = '0; hook_sel = 1'b0;
        @(negedge clk);
        test_reset();
        test_straight_line();
        test_back_to_back();
        test_branch();
        test_acc_fetch();
        test_wrap();
        test_collision();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program counter / instruction memory address width.
REQ-002 SHALL have parameter HALT_INST, default 9'h1FF, meaning the instruction encoding that ends a program.
REQ-003 SHALL have parameter NOP_INST, default 9'h1E0, meaning the encoding driven on inst when not running (decodes to no enables).
REQ-004 SHALL have clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle pulse that launches a program from address 0.
REQ-008 imem_addr  output  PC_W  instruction memory address, equal to pc.
REQ-009 imem_data  input  9  instruction word at imem_addr, combinational read.
REQ-010 inst  output  9  instruction presented to the control decoder.
REQ-011 branch_en  input  1  taken-branch indication from the control decoder for the current inst.
REQ-012 fetch_acc_en  input  1  accumulator-constant fetch indication from the control decoder.
REQ-013 acc_value  output  8  constant looked up from the ACC table by inst[4:0].
REQ-014 lut_we  input  1  table write strobe.
REQ-015 lut_sel  input  1  0 = branch table, 1 = ACC table.
REQ-016 lut_addr  input  5  table entry index.
REQ-017 lut_wdata  input  PC_W  write data; ACC table takes bits [7:0].
REQ-018 busy  output  1  high while in RUN.
REQ-019 done  output  1  high while in DONE.
REQ-020 cycles  output  16  count of RUN cycles of the current/last program.

Function
REQ-021 SHALL implement states IDLE, RUN, DONE.
REQ-022 IDLE: start=1 -> RUN, pc<=0, cycles<=0; else stay.
REQ-023 RUN: inst = imem_data (combinational, same cycle as imem_addr=pc); start ignored.
REQ-024 RUN, inst==HALT_INST: next state DONE, pc holds, branch_en/fetch_acc_en ignored.
REQ-025 RUN, not halt, branch_en=1: pc <= branch_table[inst[4:0]] at next edge.
REQ-026 RUN, not halt, branch_en=0: pc <= pc+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
REQ-027 cycles SHALL increment by 1 every RUN cycle including the halt cycle, saturating at 16'hFFFF.
REQ-028 DONE: done=1, pc and cycles hold; start=1 -> RUN with pc<=0, cycles<=0.
REQ-029 In IDLE and DONE, inst SHALL equal NOP_INST regardless of imem_data.
REQ-030 acc_value SHALL be acc_table[inst[4:0]] combinationally in all states; consumer samples it only when fetch_acc_en=1.
REQ-031 Tables: 32 entries each; branch entries PC_W bits, ACC entries 8 bits.
REQ-032 lut_we=1 SHALL write lut_wdata to the table chosen by lut_sel at lut_addr on the clock edge, in any state.
REQ-033 Write/read same entry same cycle: read returns the old value; new value visible the following cycle.
REQ-034 busy = (state==RUN); done = (state==DONE); mutually exclusive.

Reset
REQ-035 reset=1 SHALL force state IDLE, pc=0, cycles=0, all table entries 0, and take priority over start and lut_we.
REQ-036 Reset asserted mid-RUN SHALL abort the program; next cycle outputs inst=NOP_INST, busy=0, done=0.
REQ-037 Post-reset outputs: imem_addr=0, inst=NOP_INST, acc_value=0, busy=0, done=0, cycles=0.

Verification
REQ-038 Straight line: imem 0..3 = 9'h000,9'h010,9'h0C1,HALT; start -> addresses 0,1,2,3, DONE with cycles=4.
REQ-039 Branch: branch_table[5]=10'd20; imem[2]=9'h165 with branch_en=1 -> next imem_addr=20, not 3.
REQ-040 ACC fetch: acc_table[7]=8'hA5; inst=9'h187 with fetch_acc_en=1 -> acc_value=8'hA5 same cycle.
REQ-041 Wrap: branch to 10'h3FF, non-branch inst there -> next imem_addr=0, busy stays 1.
REQ-042 Table write collision: write branch_table[3]=50 while inst[4:0]=3 and branch_en=1 -> pc takes old entry; repeat branch next pass -> pc=50.
REQ-043 Reset mid-run at cycle 5 with start also high -> IDLE, pc=0, cycles=0, tables cleared, inst=NOP_INST.
